// File: rtl/depth_test_unit_if.sv
// depth_test_unit_if: fragment stream plus frame-buffer read/write ports of depth_test_unit.
interface depth_test_unit_if #(
    parameter int HORIZ_RESOLUTION = 80,
    parameter int VERT_RESOLUTION = 60,
    parameter int COLOR_DEPTH = 12,
    parameter int Z_DEPTH = 8
);
    localparam int HW = $clog2(HORIZ_RESOLUTION);
    localparam int VW = $clog2(VERT_RESOLUTION);
    localparam int PW = Z_DEPTH + COLOR_DEPTH;
    logic frag_valid;
    logic frag_ready;
    logic [HW-1:0] frag_x;
    logic [VW-1:0] frag_y;
    logic [Z_DEPTH-1:0] frag_z;
    logic [COLOR_DEPTH-1:0] frag_color;
    logic [HW-1:0] read_horiz_addr;
    logic [VW-1:0] read_vert_addr;
    logic [PW-1:0] read_pixel_data;
    logic [HW-1:0] write_horiz_addr;
    logic [VW-1:0] write_vert_addr;
    logic write_en;
    logic [PW-1:0] write_pixel_data;
    modport master (
        output frag_valid, frag_x, frag_y, frag_z, frag_color, read_pixel_data,
        input frag_ready, read_horiz_addr, read_vert_addr,
        input write_horiz_addr, write_vert_addr, write_en, write_pixel_data
    );
    modport slave (
        input frag_valid, frag_x, frag_y, frag_z, frag_color, read_pixel_data,
        output frag_ready, read_horiz_addr, read_vert_addr,
        output write_horiz_addr, write_vert_addr, write_en, write_pixel_data
    );
endinterface

// File: rtl/depth_test_unit.sv
// depth_test_unit: pipelined Z-buffer read-compare-write stage, stalls on same-pixel hazards.
// Define DEPTH_TEST_STATS_EN to add saturating pass/fail counters.
module depth_test_unit #(
    parameter int HORIZ_RESOLUTION = 80,
    parameter int VERT_RESOLUTION = 60,
    parameter int COLOR_DEPTH = 12,
    parameter int Z_DEPTH = 8,
    parameter int READ_LATENCY = 2,
    parameter bit DEPTH_LE = 1'b0
) (
    input logic i_clk,
    input logic i_srst_n,
    depth_test_unit_if.slave bus,
`ifdef DEPTH_TEST_STATS_EN
    input logic i_stats_clear,
    output logic [15:0] o_pass_count,
    output logic [15:0] o_fail_count,
`endif
    output logic o_idle
);
    localparam int HW = $clog2(HORIZ_RESOLUTION);
    localparam int VW = $clog2(VERT_RESOLUTION);
    localparam int LAST = READ_LATENCY - 1;
    logic [READ_LATENCY-1:0] pv;
    logic [HW-1:0] px [READ_LATENCY];
    logic [VW-1:0] py [READ_LATENCY];
    logic [Z_DEPTH-1:0] pz [READ_LATENCY];
    logic [COLOR_DEPTH-1:0] pc [READ_LATENCY];
    logic hazard, accept, pass;
    assign bus.read_horiz_addr = bus.frag_x;
    assign bus.read_vert_addr = bus.frag_y;
    always_comb begin
        hazard = bus.write_en && bus.write_horiz_addr == bus.frag_x && bus.write_vert_addr == bus.frag_y;
        for (int i = 0; i < READ_LATENCY; i++)
            hazard = hazard | (pv[i] && px[i] == bus.frag_x && py[i] == bus.frag_y);
    end
    assign bus.frag_ready = i_srst_n && !hazard;
    assign accept = bus.frag_valid && bus.frag_ready;
    // Padding the fragment z with all-ones (strict) or all-zeros (LE) lets one full-word
    // compare against the stored word decide on the Z field alone.
    assign pass = pv[LAST] && (DEPTH_LE ? {pz[LAST], {COLOR_DEPTH{1'b0}}} <= bus.read_pixel_data
                                        : {pz[LAST], {COLOR_DEPTH{1'b1}}} < bus.read_pixel_data);
    assign o_idle = !(|pv) && !bus.write_en;
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            pv <= '0;
            bus.write_en <= 1'b0;
            bus.write_horiz_addr <= '0;
            bus.write_vert_addr <= '0;
            bus.write_pixel_data <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) pv[i] <= pv[i-1];
            bus.write_en <= pass;
            if (pass) begin
                bus.write_horiz_addr <= px[LAST];
                bus.write_vert_addr <= py[LAST];
                bus.write_pixel_data <= {pz[LAST], pc[LAST]};
            end
        end
    end
    always_ff @(posedge i_clk) begin
        px[0] <= bus.frag_x;
        py[0] <= bus.frag_y;
        pz[0] <= bus.frag_z;
        pc[0] <= bus.frag_color;
        for (int i = 1; i < READ_LATENCY; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pz[i] <= pz[i-1];
            pc[i] <= pc[i-1];
        end
    end
`ifdef DEPTH_TEST_STATS_EN
    logic fail;
    assign fail = pv[LAST] && !pass;
    always_ff @(posedge i_clk) begin
        if (!i_srst_n || i_stats_clear) begin
            o_pass_count <= '0;
            o_fail_count <= '0;
        end else begin
            o_pass_count <= o_pass_count + {15'd0, pass && !(&o_pass_count)};
            o_fail_count <= o_fail_count + {15'd0, fail && !(&o_fail_count)};
        end
    end
`endif
endmodule
